// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flop, one bit pair per clock, LSB first.
// Result is a+b mod 2^WIDTH with the carry out of the MSB reported separately.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t         state, state_nx;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic           c;
    logic [CW-1:0]  cnt;
    logic           s, c_nx, last;

    always_comb begin
        s    = a_sh[0] ^ b_sh[0] ^ c;
        c_nx = (a_sh[0] & b_sh[0]) | (c & (a_sh[0] ^ b_sh[0]));
        last = (cnt == CW'(WIDTH - 1));
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: if (start) state_nx = RUN;
            RUN: begin
                busy = 1'b1;
                if (last) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Sum bits fill the MSB vacated by each shift of a_sh, so after WIDTH
    // shifts a_sh itself is the LSB-aligned result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh <= '0;
            b_sh <= '0;
            c    <= 1'b0;
            cnt  <= '0;
            sum  <= '0;
            cout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh <= a;
                        b_sh <= b;
                        c    <= 1'b0;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    a_sh <= {s, a_sh[WIDTH-1:1]};
                    b_sh <= {1'b0, b_sh[WIDTH-1:1]};
                    c    <= c_nx;
                    cnt  <= cnt + CW'(1);
                    if (last) begin
                        sum  <= {s, a_sh[WIDTH-1:1]};
                        cout <= c_nx;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=4): directed cases, random operands,
// and every operand pair in shuffled order, checked against plain a+b arithmetic.
module tb_serial_adder;

    localparam int W = 4;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b1;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic [W-1:0] sum;
    logic         cout, busy, done;

    int unsigned  total  = 0;
    int unsigned  passed = 0;
    int           cyc    = 0;
    logic [W-1:0] last_sum  = '0;
    logic         last_cout = 1'b0;

    serial_adder #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .sum  (sum),
        .cout (cout),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    // Called at a negedge while idle; returns at the negedge of the first IDLE cycle after done.
    task automatic do_add(input logic [W-1:0] x, input logic [W-1:0] y, input bit poke);
        int           busy_n = 0;
        bit           got    = 0;
        logic [W:0]   exp_v;
        exp_v = {1'b0, x} + {1'b0, y};
        a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = W'($urandom); b = W'($urandom);
        for (int i = 0; i < 3 * W && !got; i++) begin
            @(negedge clk);
            if (poke) begin
                if (i == 1) begin start = 1'b1; a = W'(7); b = W'(7); end
                else start = 1'b0;
            end
            chk("busy_done_excl", busy & done, 0);
            if (done) begin
                got = 1;
                chk("sum", sum, exp_v[W-1:0]);
                chk("cout", cout, exp_v[W]);
                chk("busy_cycles", busy_n, W);
            end else begin
                if (busy) busy_n++;
                chk("sum_hold_run", sum, last_sum);
                chk("cout_hold_run", cout, last_cout);
            end
        end
        chk("done_seen", got, 1);
        last_sum  = exp_v[W-1:0];
        last_cout = exp_v[W];
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("sum_held_after", sum, last_sum);
        chk("cout_held_after", cout, last_cout);
    endtask

    initial begin
        #1000000;
        $error("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         order[256];
        logic [W:0] expq[$];
        int         idx, ndone, prev_cyc, j, tmp;
        logic [W-1:0] ra, rb;

        // Reset held with start asserted
        #12;
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);
        end

        do_add(4'd5, 4'd3, 0);
        repeat (2) begin
            @(negedge clk);
            chk("sum_stays", sum, 8);
        end
        do_add(4'd15, 4'd1, 0);
        do_add(4'd15, 4'd15, 0);

        // Start re-asserted during RUN is ignored
        do_add(4'd2, 4'd2, 1);
        repeat (8) begin
            @(negedge clk);
            chk("no_extra_done", done, 0);
            chk("no_extra_busy", busy, 0);
        end

        // Reset in the middle of an operation
        a = 4'd9; b = 4'd6; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("midop_busy", busy, 1);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_sum", sum, 0);
        chk("midrst_cout", cout, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk("aborted_no_done", done, 0);
            chk("aborted_no_busy", busy, 0);
        end
        last_sum = '0; last_cout = 1'b0;
        do_add(4'd1, 4'd1, 0);

        // Random operands with idle gaps
        repeat (20) begin
            ra = W'($urandom);
            rb = W'($urandom);
            do_add(ra, rb, 0);
            repeat ($urandom_range(2, 0)) @(negedge clk);
        end

        // All pairs, shuffled, start held high
        for (int i = 0; i < 256; i++) order[i] = i;
        for (int i = 255; i > 0; i--) begin
            j = $urandom_range(i, 0);
            tmp = order[i]; order[i] = order[j]; order[j] = tmp;
        end
        a = W'(order[0] >> W); b = W'(order[0]);
        expq.push_back({1'b0, a} + {1'b0, b});
        start = 1'b1;
        idx = 1; ndone = 0; prev_cyc = 0;
        for (int t = 0; t < 256 * (W + 2) + 20 && ndone < 256; t++) begin
            @(negedge clk);
            if (busy && done) chk("exh_busy_done_excl", busy & done, 0);
            if (done) begin
                if (expq.size() == 0) chk("exh_extra_done", 1, 0);
                else chk("exh_sum_cout", {cout, sum}, expq.pop_front());
                if (ndone > 0) chk("done_spacing", cyc - prev_cyc, W + 2);
                prev_cyc = cyc;
                ndone++;
                if (idx < 256) begin
                    a = W'(order[idx] >> W); b = W'(order[idx]);
                    expq.push_back({1'b0, a} + {1'b0, b});
                    idx++;
                end else begin
                    start = 1'b0;
                end
            end
        end
        chk("exh_count", ndone, 256);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
